// File: rtl/clint_prio.sv
// rtl/clint_prio.sv - core-local interrupt controller with per-source masking and trap-entry CSR sequencing
module clint_prio #(
    parameter int NUM_IRQ        = 8,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter bit VECTORED_EN    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               global_int_en_i,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [31:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [NUM_IRQ-1:0] irq_claim_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_JUMP,
        S_MRET,
        S_JUMP_MRET
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] pend_act;
    logic [3:0]         win_k;
    logic               win_found;
    logic               req_sync;
    logic               req_async;
    logic               req_mret;
    logic [31:0]        epc_q;
    logic [31:0]        cause_q;
    logic               async_q;
    logic [3:0]         k_q;
    logic [31:0]        vec_base;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        pend_act  = pend & irq_en_i;
        win_found = 1'b0;
        win_k     = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_act[i]) begin
                win_found = 1'b1;
                win_k     = 4'(i);
            end
        end
    end

    assign req_sync  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    assign req_async = global_int_en_i && win_found;
    assign req_mret  = (inst_i == INST_MRET);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_sync || req_async) begin
                    state_nxt = S_MEPC;
                end else if (req_mret) begin
                    state_nxt = S_MRET;
                end
            end
            S_MEPC:      state_nxt = S_MSTATUS;
            S_MSTATUS:   state_nxt = S_MCAUSE;
            S_MCAUSE:    state_nxt = S_JUMP;
            S_JUMP:      state_nxt = S_IDLE;
            S_MRET:      state_nxt = S_JUMP_MRET;
            S_JUMP_MRET: state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    assign vec_base = {csr_mtvec[31:2], 2'b00};

    always_comb begin
        hold_flag_o  = (state != S_IDLE) || req_sync || req_async || req_mret;
        we_o         = 1'b0;
        waddr_o      = 32'd0;
        data_o       = 32'd0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'd0;
        irq_claim_o  = '0;
        case (state)
            S_MEPC: begin
                we_o    = 1'b1;
                waddr_o = CSR_MEPC;
                data_o  = epc_q;
            end
            S_MSTATUS: begin
                we_o      = 1'b1;
                waddr_o   = CSR_MSTATUS;
                data_o    = csr_mstatus;
                data_o[7] = csr_mstatus[3];
                data_o[3] = 1'b0;
            end
            S_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = CSR_MCAUSE;
                data_o  = cause_q;
            end
            S_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = vec_base;
                // Vectored offset applies to interrupts only; exceptions always use the base.
                if (VECTORED_EN && (csr_mtvec[1:0] == 2'b01) && async_q) begin
                    int_addr_o = vec_base + {cause_q[29:0], 2'b00};
                end
                if (async_q) begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        irq_claim_o[i] = (k_q == 4'(i));
                    end
                end
            end
            S_MRET: begin
                we_o      = 1'b1;
                waddr_o   = CSR_MSTATUS;
                data_o    = csr_mstatus;
                data_o[3] = csr_mstatus[7];
                data_o[7] = 1'b1;
            end
            S_JUMP_MRET: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pend    <= '0;
            epc_q   <= 32'd0;
            cause_q <= 32'd0;
            async_q <= 1'b0;
            k_q     <= 4'd0;
        end else begin
            state <= state_nxt;
            pend  <= (pend & ~irq_claim_o) | irq_i;
            if (state == S_IDLE) begin
                if (req_sync) begin
                    epc_q   <= jump_flag_i ? (jump_addr_i - 32'd4) : inst_addr_i;
                    cause_q <= (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
                    async_q <= 1'b0;
                end else if (req_async) begin
                    epc_q   <= jump_flag_i ? jump_addr_i : inst_addr_i;
                    cause_q <= {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(win_k)};
                    async_q <= 1'b1;
                    k_q     <= win_k;
                end
            end
        end
    end

endmodule
